// File: rtl/generador_excitacion_jk.sv
// generador_excitacion_jk: programmable JK excitation generator.
// A sequence of up to DEPTH states is loaded into a small table. Each step
// request then drives a one-cycle J/K pulse that moves the external JK
// flip-flop bank from its fed-back Q to the next table entry.
// Optional feature macro: GEN_JK_CHECK_EN adds a CHECK state that compares
// the bank's Q against the target and raises a sticky ERR on mismatch.

// Minimal excitation for one flip-flop: set when 0->1, reset when 1->0.
module generador_excitacion_jk_lane (
    input  logic q_i,
    input  logic t_i,
    output logic j_o,
    output logic k_o
);
    assign j_o = ~q_i & t_i;
    assign k_o = q_i & ~t_i;
endmodule

module generador_excitacion_jk #(
    parameter int N     = 4,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          c_i,
    input  logic          r_i,
    input  logic          load_i,
    input  logic [N-1:0]  ld_data_i,
    input  logic          ld_last_i,
    output logic          ld_ready_o,
    input  logic          en_i,
    input  logic [N-1:0]  q_i,
    output logic [N-1:0]  j_o,
    output logic [N-1:0]  k_o,
    output logic [AW-1:0] idx_o,
    output logic          valid_o,
    output logic          busy_o,
    output logic          err_o
);
    typedef enum logic [1:0] {S_LOAD, S_WAIT, S_PULSE, S_CHECK} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   tbl_q [DEPTH];
    logic [AW-1:0]  wp_q, wp_d;
    logic [AW-1:0]  last_q, last_d;     // index of final entry (length-1)
    logic [AW-1:0]  idx_q, idx_d;
    logic [N-1:0]   j_q, j_d, k_q, k_d;
    logic           err_q, err_d;
    logic [N-1:0]   tgt, jx, kx;
    logic           wr_en, load_done, step;

    assign wr_en     = (state_q == S_LOAD) && load_i;
    assign load_done = wr_en && (ld_last_i || (wp_q == AW'(DEPTH - 1)));
    assign step      = (state_q == S_WAIT) && en_i;

    // Per-bit excitation against the entry that becomes current at this edge
    genvar b;
    generate
        for (b = 0; b < N; b++) begin : g_lane
            generador_excitacion_jk_lane u_lane (
                .q_i (q_i[b]),
                .t_i (tgt[b]),
                .j_o (jx[b]),
                .k_o (kx[b])
            );
        end
    endgenerate

    // State register
    always_ff @(posedge c_i) begin
        if (r_i) state_q <= S_LOAD;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  if (load_done) state_d = S_PULSE;
            S_WAIT:  if (en_i)      state_d = S_PULSE;
`ifdef GEN_JK_CHECK_EN
            S_PULSE: state_d = S_CHECK;
`else
            S_PULSE: state_d = S_WAIT;
`endif
            S_CHECK: state_d = S_WAIT;
            default: state_d = S_LOAD;
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        ld_ready_o = (state_q == S_LOAD);
        valid_o    = (state_q != S_LOAD);
        busy_o     = (state_q == S_PULSE) || (state_q == S_CHECK);
    end

    // Datapath next values: pointers, target index, excitation, error flag
    always_comb begin
        wp_d   = wr_en ? wp_q + 1'b1 : wp_q;
        last_d = load_done ? wp_q : last_q;
        idx_d  = idx_q;
        if (load_done)
            idx_d = '0;
        else if (step)
            idx_d = (idx_q == last_q) ? '0 : idx_q + 1'b1;
        // The final entry is written at the same edge the sync pulse is
        // launched, so bypass the table when it is the target.
        tgt = (wr_en && (idx_d == wp_q)) ? ld_data_i : tbl_q[idx_d];
        j_d = (load_done || step) ? jx : '0;
        k_d = (load_done || step) ? kx : '0;
`ifdef GEN_JK_CHECK_EN
        err_d = err_q || ((state_q == S_CHECK) && (q_i != tbl_q[idx_q]));
`else
        err_d = 1'b0;
`endif
    end

    // Control and output registers
    always_ff @(posedge c_i) begin
        if (r_i) begin
            wp_q   <= '0;
            last_q <= '0;
            idx_q  <= '0;
            j_q    <= '0;
            k_q    <= '0;
            err_q  <= 1'b0;
        end else begin
            wp_q   <= wp_d;
            last_q <= last_d;
            idx_q  <= idx_d;
            j_q    <= j_d;
            k_q    <= k_d;
            err_q  <= err_d;
        end
    end

    // Sequence table, only writable while loading; contents survive reset
    always_ff @(posedge c_i) begin
        if (!r_i && wr_en) tbl_q[wp_q] <= ld_data_i;
    end

    assign j_o   = j_q;
    assign k_o   = k_q;
    assign idx_o = idx_q;
    assign err_o = err_q;
endmodule

// File: tb/tb_generador_excitacion_jk.sv
// Bench for generador_excitacion_jk: drives a behavioural JK flip-flop bank
// from J/K and checks against a sequence/index model kept in queues.
module tb_generador_excitacion_jk;
    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          c = 1'b0;
    logic          r, load, ld_last, en;
    logic [N-1:0]  ld_data, q, j, k;
    logic [AW-1:0] idx;
    logic          ld_ready, valid, busy, err;

    // bank override, used for reset and fault injection
    logic          fq;
    logic [N-1:0]  fval;

    int            total = 0;
    int            bad   = 0;
    logic [N-1:0]  seq[$];
    logic [N-1:0]  stage[DEPTH];
    int            midx;
    bit            merr;

    generador_excitacion_jk #(.N(N), .DEPTH(DEPTH)) dut (
        .c_i(c), .r_i(r), .load_i(load), .ld_data_i(ld_data),
        .ld_last_i(ld_last), .ld_ready_o(ld_ready), .en_i(en), .q_i(q),
        .j_o(j), .k_o(k), .idx_o(idx), .valid_o(valid), .busy_o(busy),
        .err_o(err)
    );

    always #5 c = ~c;

    // JK flip-flop bank: Q+ = J&~Q | ~K&Q
    always @(posedge c) begin
        if (fq) q <= fval;
        else    q <= (j & ~q) | (~k & q);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge c);
        #1;
    endtask

    task automatic do_reset;
        r = 1'b1; load = 1'b0; ld_last = 1'b0; en = 1'b0; ld_data = '0;
        fq = 1'b1; fval = '0;
        tick; tick;
        r = 1'b0; fq = 1'b0;
        seq.delete(); midx = 0; merr = 1'b0;
    endtask

    // Remainder of a pulse: bank update, then CHECK (if present), then WAIT
    task automatic finish_pulse(input logic [N-1:0] t, input bit force_q, input logic [N-1:0] fv);
        if (force_q) begin fq = 1'b1; fval = fv; end
        tick;
        fq = 1'b0;
        chk("j_zero", j, 0);
        chk("k_zero", k, 0);
        chk("q_after", q, force_q ? fv : t);
`ifdef GEN_JK_CHECK_EN
        if (force_q && fv != t) merr = 1'b1;
        chk("busy_check", busy, 1);
        tick;
`endif
        chk("err", err, merr);
        chk("busy_wait", busy, 0);
        chk("valid", valid, 1);
    endtask

    task automatic load_seq(input int n, input bit use_last);
        logic [N-1:0] t;
        chk("ld_ready_pre", ld_ready, 1);
        for (int i = 0; i < n; i++) begin
            load = 1'b1; ld_data = stage[i]; ld_last = use_last && (i == n - 1);
            seq.push_back(stage[i]);
            tick;
        end
        load = 1'b0; ld_last = 1'b0;
        midx = 0;
        t = seq[0];
        chk("sync_j", j, t & ~q);
        chk("sync_k", k, q & ~t);
        chk("sync_idx", idx, 0);
        chk("sync_ready", ld_ready, 0);
        chk("sync_busy", busy, 1);
        finish_pulse(t, 1'b0, '0);
    endtask

    task automatic do_step(input bit force_q, input logic [N-1:0] fv);
        logic [N-1:0] t;
        en = 1'b1;
        tick;
        en = 1'b0;
        midx = (midx + 1) % seq.size();
        t = seq[midx];
        chk("step_idx", idx, midx);
        chk("step_j", j, t & ~q);
        chk("step_k", k, q & ~t);
        chk("step_busy", busy, 1);
        finish_pulse(t, force_q, fv);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cnt, steps, exp_steps, exp_busy, n;
        logic [AW-1:0] prev;

        // reset state
        r = 1'b1; load = 1'b1; ld_data = 4'hA; ld_last = 1'b1;
        do_reset;
        chk("rst_ready", ld_ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_j", j, 0);
        chk("rst_k", k, 0);
        chk("rst_idx", idx, 0);

        // 3,7,1 then three steps with wrap
        stage[0] = 4'd3; stage[1] = 4'd7; stage[2] = 4'd1;
        load_seq(3, 1'b1);
        chk("q_sync", q, 3);
        repeat (3) do_step(1'b0, '0);
        chk("wrap_idx", idx, 0);
        chk("wrap_q", q, 3);

        // EN held high for 6 cycles
`ifdef GEN_JK_CHECK_EN
        exp_steps = 2; exp_busy = 4;
`else
        exp_steps = 3; exp_busy = 3;
`endif
        busy_cnt = 0; steps = 0; prev = idx;
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (busy) busy_cnt++;
            if (idx !== prev) steps++;
            prev = idx;
        end
        en = 1'b0;
        midx = (midx + exp_steps) % seq.size();
        chk("hold_steps", steps, exp_steps);
        chk("hold_busy", busy_cnt, exp_busy);
        chk("hold_idx", idx, midx);
        chk("hold_q", q, seq[midx]);

        // feedback mismatch: Q forced to 5 while target is 7
        do_reset;
        load_seq(3, 1'b1);
        do_step(1'b1, 4'd5);
        do_step(1'b0, '0);
        do_step(1'b0, '0);
`ifdef GEN_JK_CHECK_EN
        chk("err_sticky", err, 1);
`else
        chk("err_off", err, 0);
`endif

        // reset during PULSE
        en = 1'b1;
        tick;
        en = 1'b0;
        chk("pre_rst_busy", busy, 1);
        r = 1'b1;
        tick;
        r = 1'b0;
        chk("mid_rst_j", j, 0);
        chk("mid_rst_k", k, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_ready", ld_ready, 1);
        chk("mid_rst_idx", idx, 0);
        chk("mid_rst_err", err, 0);

        // length 1: stepping re-targets entry 0, no excitation needed
        do_reset;
        stage[0] = 4'd5;
        load_seq(1, 1'b1);
        do_step(1'b0, '0);
        do_step(1'b0, '0);

        // full table without LD_LAST, extra LOAD ignored
        do_reset;
        for (int i = 0; i < DEPTH; i++) stage[i] = 4'($urandom);
        load_seq(DEPTH, 1'b0);
        load = 1'b1; ld_data = ~seq[1]; ld_last = 1'b1;
        tick;
        load = 1'b0; ld_last = 1'b0;
        chk("full_ready", ld_ready, 0);
        chk("full_idx", idx, 0);
        repeat (DEPTH + 1) do_step(1'b0, '0);

        // randomized sequences, gaps and occasional forced feedback
        for (int round = 0; round < 8; round++) begin
            do_reset;
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < DEPTH; i++) stage[i] = 4'($urandom);
            load_seq(n, (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1)));
            repeat ($urandom_range(3, 12)) begin
                repeat ($urandom_range(0, 2)) tick;
                do_step($urandom_range(0, 4) == 0, 4'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
